// File: rtl/systolic_data_deskew_if.sv
// rtl/systolic_data_deskew_if.sv - skewed-in / aligned-out row bus of the systolic deskewer
interface systolic_data_deskew_if #(
  parameter int MATRIX_WIDTH = 14,
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_ROWS     = 14
);
  localparam int IDX_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

  logic                                   in_valid;
  logic [MATRIX_WIDTH-1:0][DATA_WIDTH-1:0] in_data;
  logic                                   out_valid;
  logic [MATRIX_WIDTH-1:0][DATA_WIDTH-1:0] out_data;
  logic [IDX_W-1:0]                       out_row_idx;
  logic                                   out_last;

  modport master (
    output in_valid, in_data,
    input  out_valid, out_data, out_row_idx, out_last
  );

  modport slave (
    input  in_valid, in_data,
    output out_valid, out_data, out_row_idx, out_last
  );
endinterface

// File: rtl/systolic_data_deskew.sv
// rtl/systolic_data_deskew.sv - realigns skewed systolic array output lanes into whole rows
module systolic_data_deskew #(
  parameter int MATRIX_WIDTH = 14,
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_ROWS     = 14
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  systolic_data_deskew_if.slave  bus
);
  localparam int IDX_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROWS - 1);

  logic [MATRIX_WIDTH-1:0][DATA_WIDTH-1:0] lane_tail;
  logic [MATRIX_WIDTH-1:0][DATA_WIDTH-1:0] out_q;
  logic [MATRIX_WIDTH-1:0]                 valid_pipe;
  logic [IDX_W-1:0]                        row_cnt;

  // Lane j waits MATRIX_WIDTH-1-j cycles so it meets lane 0 of the same row.
  for (genvar j = 0; j < MATRIX_WIDTH; j++) begin : g_lane
    localparam int DEPTH = MATRIX_WIDTH - 1 - j;
    if (DEPTH == 0) begin : g_direct
      assign lane_tail[j] = bus.in_data[j];
    end else begin : g_chain
      logic [DATA_WIDTH-1:0] chain [DEPTH];
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int k = 0; k < DEPTH; k++) chain[k] <= '0;
        end else if (enable) begin
          chain[0] <= bus.in_data[j];
          for (int k = 1; k < DEPTH; k++) chain[k] <= chain[k-1];
        end
      end
      assign lane_tail[j] = chain[DEPTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q      <= '0;
      valid_pipe <= '0;
      row_cnt    <= '0;
    end else if (enable) begin
      out_q      <= lane_tail;
      valid_pipe <= {valid_pipe[MATRIX_WIDTH-2:0], bus.in_valid};
      // The row on the output is consumed on this edge, so move to the next index.
      if (valid_pipe[MATRIX_WIDTH-1]) begin
        row_cnt <= (row_cnt == LAST_IDX) ? '0 : row_cnt + 1'b1;
      end
    end
  end

  assign bus.out_data    = out_q;
  assign bus.out_valid   = valid_pipe[MATRIX_WIDTH-1];
  assign bus.out_row_idx = row_cnt;
  assign bus.out_last    = valid_pipe[MATRIX_WIDTH-1] && (row_cnt == LAST_IDX);
endmodule
